regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Access controller in front of the 32x32 register file (ports clk, WE3, A1, A2, A3, WD3, RD1, RD2) of the single-cycle RISC-V core.
- Shares the single write port (A3/WD3/WE3) and read port 1 (A1/RD1) between core writeback and a debug requester.
- Debug side uses a valid/ready handshake.
- Sequences a post-reset clear of all registers.
- Stalls the core whenever the core must yield a port.

Parameters:
NREG, 32, number of registers to clear; addresses 0..NREG-1
AW, 5, register address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive blocked cycles before a pending debug write pre-empts core writeback; range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
core_we  in  1  core writeback request
core_wa  in  AW  core writeback address
core_wd  in  DW  core writeback data
core_a1  in  AW  core read address, port 1
core_stall  out  1  core must hold PC and re-present its writeback next cycle
dbg_valid  in  1  debug request valid
dbg_wr  in  1  1 = write, 0 = read
dbg_addr  in  AW  debug register address
dbg_wdata  in  DW  debug write data
dbg_ready  out  1  debug request accepted this cycle (valid & ready)
dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid
dbg_rdata  out  DW  registered debug read data
rf_WE3  out  1  to RegFile WE3
rf_A3  out  AW  to RegFile A3
rf_WD3  out  DW  to RegFile WD3
rf_A1  out  AW  to RegFile A1
rf_RD1  in  DW  from RegFile RD1; also wired directly to the core

Behaviour:
- States: CLEAR, RUN.
  - rst_n low at a clock edge: next state CLEAR, clear index 0, starve counter 0, dbg_rvalid 0, dbg_rdata 0.
- While rst_n is low, the combinational outputs are forced: core_stall=1, dbg_ready=0, rf_WE3=0, rf_A3=0, rf_WD3=0, rf_A1=core_a1.
- CLEAR state:
  - Each cycle: rf_WE3=1, rf_A3=index, rf_WD3=0, core_stall=1, dbg_ready=0.
  - Index increments each cycle.
  - After writing NREG-1, transition to RUN. CLEAR lasts exactly NREG cycles.
  - Reset asserted mid-clear restarts CLEAR from index 0.
- RUN state, priority evaluated combinationally each cycle:
  1. Debug read (dbg_valid & !dbg_wr):
     - dbg_ready=1, core_stall=1, rf_A1=dbg_addr, rf_WE3=0 (the stalled core write does not commit).
     - dbg_rdata<=rf_RD1 at the edge; dbg_rvalid=1 for the following cycle only.
     - Back-to-back reads give back-to-back rvalid pulses.
  2. Debug write, core idle (dbg_valid & dbg_wr & !core_we):
     - dbg_ready=1, core_stall=0.
     - rf_WE3/rf_A3/rf_WD3 = 1/dbg_addr/dbg_wdata.
     - Starve counter cleared.
  3. Debug write, core writing, counter==STARVE_LIMIT:
     - Same as rule 2, except core_stall=1.
     - Starve counter cleared.
  4. Debug write, core writing, counter<STARVE_LIMIT:
     - dbg_ready=0, core write passes through.
     - Counter increments.
  5. No debug request:
     - Core write passes through (rf_WE3=core_we, rf_A3=core_wa, rf_WD3=core_wd, rf_A1=core_a1), core_stall=0.
     - Counter cleared.
- Address 0: any RUN-state write (core or debug) with address 0 drives rf_WE3=0, but the handshake still completes. A debug read of address 0 returns whatever RegFile supplies.
- core_stall and dbg_ready are combinational; every other registered output updates only on a clock edge.
- The starve counter saturates at STARVE_LIMIT and never wraps.

Optional Feature:
Macro RFCTL_CLEAR_EN.
- Defined: CLEAR state as described above.
- Undefined: CLEAR state and clear index are absent; the first edge with rst_n high enters RUN directly, and core_stall=0 from that cycle. Register contents after reset are whatever RegFile holds.

Test Plan:
- Reset/clear: rst_n=0 for 2 cycles, then 1 -> 32 cycles of rf_WE3=1, rf_A3=0..31, rf_WD3=0, core_stall=1; cycle 33 core_stall=0.
- Core pass-through: core_we=1, core_wa=2, core_wd=3 -> same cycle rf_WE3=1, rf_A3=2, rf_WD3=3. Then core_wa=0 -> rf_WE3=0.
- Debug write, idle core: dbg_valid=1, dbg_wr=1, dbg_addr=5, dbg_wdata=0xDEADBEEF, core_we=0 -> dbg_ready=1, rf_A3=5, rf_WD3=0xDEADBEEF, core_stall=0.
- Starvation: core_we=1 held, debug write to x7 pending -> dbg_ready=0 for 4 cycles; 5th cycle dbg_ready=1, core_stall=1, rf_A3=7.
- Debug read: after the x5 write, dbg_valid=1, dbg_wr=0, dbg_addr=5 -> core_stall=1, rf_A1=5, rf_WE3=0; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
- Reset mid-clear: drop rst_n at clear index 10 for 1 cycle -> clear restarts at rf_A3=0; core_stall stays 1 until 32 further cycles elapse.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the RegFile write port and read port 1 between core writeback and a debug requester.
// Define RFCTL_CLEAR_EN to zero all registers in a CLEAR sequence after reset; undefined, RUN starts at once.
module regfile_access_ctrl #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_we,
  input  logic [AW-1:0] core_wa,
  input  logic [DW-1:0] core_wd,
  input  logic [AW-1:0] core_a1,
  output logic          core_stall,
  input  logic          dbg_valid,
  input  logic          dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ready,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          rf_WE3,
  output logic [AW-1:0] rf_A3,
  output logic [DW-1:0] rf_WD3,
  output logic [AW-1:0] rf_A1,
  input  logic [DW-1:0] rf_RD1
);

  localparam int            CW    = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  if (NREG < 1 || NREG > (1 << AW)) begin : g_bad_nreg
    $error("NREG must fit in the AW-bit address space");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must lie in 1..15");
  end

  logic          in_clear;
  logic [AW-1:0] clr_addr;

`ifdef RFCTL_CLEAR_EN
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + AW'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d   = S_RUN;
        clr_idx_d = '0;
      end
    end
  end

  assign in_clear = (state_q == S_CLEAR);
  assign clr_addr = clr_idx_q;
`else
  assign in_clear = 1'b0;
  assign clr_addr = '0;
`endif

  logic          run_ok;
  logic          starved;
  logic          grant_rd;
  logic          grant_wr;
  logic          blocked_wr;
  logic [CW-1:0] starve_q, starve_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Reads always win; a debug write only displaces a live core write once it has starved long enough.
  assign run_ok     = rst_n & ~in_clear;
  assign starved    = (starve_q == LIMIT);
  assign grant_rd   = run_ok & dbg_valid & ~dbg_wr;
  assign grant_wr   = run_ok & dbg_valid & dbg_wr & (~core_we | starved);
  assign blocked_wr = run_ok & dbg_valid & dbg_wr & core_we & ~starved;

  always_comb begin
    core_stall = 1'b0;
    dbg_ready  = 1'b0;
    rf_WE3     = core_we & (core_wa != '0);
    rf_A3      = core_wa;
    rf_WD3     = core_wd;
    rf_A1      = core_a1;
    if (!rst_n) begin
      core_stall = 1'b1;
      rf_WE3     = 1'b0;
      rf_A3      = '0;
      rf_WD3     = '0;
    end else if (in_clear) begin
      core_stall = 1'b1;
      rf_WE3     = 1'b1;
      rf_A3      = clr_addr;
      rf_WD3     = '0;
    end else if (grant_rd) begin
      dbg_ready  = 1'b1;
      core_stall = 1'b1;
      rf_WE3     = 1'b0;
      rf_A1      = dbg_addr;
    end else if (grant_wr) begin
      dbg_ready  = 1'b1;
      core_stall = core_we;
      rf_WE3     = (dbg_addr != '0);
      rf_A3      = dbg_addr;
      rf_WD3     = dbg_wdata;
    end
  end

  always_comb begin
    starve_d = '0;
    if (blocked_wr) begin
      starve_d = (starve_q < LIMIT) ? starve_q + CW'(1) : starve_q;
    end else if (grant_rd) begin
      starve_d = starve_q;
    end
    rvalid_d = grant_rd;
    rdata_d  = grant_rd ? rf_RD1 : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a RegFile stand-in and a reference model.
`timescale 1ns/1ps
module tb_regfile_access_ctrl;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int LIM  = 4;
`ifdef RFCTL_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_we;
  logic [AW-1:0] core_wa;
  logic [DW-1:0] core_wd;
  logic [AW-1:0] core_a1;
  logic          core_stall;
  logic          dbg_valid;
  logic          dbg_wr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ready;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          rf_WE3;
  logic [AW-1:0] rf_A3;
  logic [DW-1:0] rf_WD3;
  logic [AW-1:0] rf_A1;
  logic [DW-1:0] rf_RD1;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd), .core_a1(core_a1),
    .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_WE3(rf_WE3), .rf_A3(rf_A3), .rf_WD3(rf_WD3), .rf_A1(rf_A1), .rf_RD1(rf_RD1)
  );

  function automatic logic [DW-1:0] seed(input int i);
    return (i == 0) ? '0 : (32'hC0DE_0000 | DW'(i * 32'h111));
  endfunction

  // RegFile stand-in: loads power-up content while stub_init is high.
  logic          stub_init;
  logic [DW-1:0] rf_mem [NREG];
  assign rf_RD1 = (rf_A1 == '0) ? '0 : rf_mem[rf_A1];
  always @(posedge clk) begin
    if (stub_init) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= seed(i);
    end else if (rf_WE3) begin
      rf_mem[rf_A3] <= rf_WD3;
    end
  end

  typedef struct {
    logic          stall, ready, we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic          chk_a3;
    logic [AW-1:0] a1;
    logic          chk_a1;
    logic          rvalid;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NREG];
  int            clear_left = 0;
  int            starve = 0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  // Effect of the cycle currently being presented, applied at the next edge
  logic          p_rst = 1'b1, p_clear = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
  logic [AW-1:0] p_wa = '0, p_ra = '0;
  logic [DW-1:0] p_wd = '0;
  int            p_starve = 0;
  logic          last_ready = 1'b0;

  task automatic commit();
    if (p_rst) begin
      clear_left = CLR_EN ? NREG : 0;
      starve     = 0;
      m_rvalid   = 1'b0;
      m_rdata    = '0;
    end else begin
      m_rvalid = p_rd;
      if (p_rd) m_rdata = (p_ra == '0) ? '0 : m_mem[p_ra];
      if (p_wr) m_mem[p_wa] = p_wd;
      if (p_clear) clear_left--;
      starve = p_starve;
    end
  endtask

  task automatic predict();
    exp_t e;
    e.stall = 1'b0; e.ready = 1'b0; e.we = 1'b0; e.a3 = '0; e.wd = '0; e.chk_a3 = 1'b0;
    e.a1 = core_a1; e.chk_a1 = 1'b1; e.rvalid = m_rvalid; e.rdata = m_rdata;
    p_rst = !rst_n; p_clear = 1'b0; p_wr = 1'b0; p_rd = 1'b0; p_starve = starve;
    if (!rst_n) begin
      e.stall = 1'b1; e.chk_a3 = 1'b1;
    end else if (clear_left > 0) begin
      e.stall = 1'b1; e.we = 1'b1; e.a3 = AW'(NREG - clear_left); e.wd = '0;
      e.chk_a3 = 1'b1; e.chk_a1 = 1'b0;
      p_clear = 1'b1; p_wr = 1'b1; p_wa = e.a3; p_wd = '0;
    end else if (dbg_valid && !dbg_wr) begin
      e.ready = 1'b1; e.stall = 1'b1; e.a1 = dbg_addr;
      p_rd = 1'b1; p_ra = dbg_addr;
    end else if (dbg_valid && dbg_wr && (!core_we || starve == LIM)) begin
      e.ready = 1'b1; e.stall = core_we; e.we = (dbg_addr != 0);
      e.a3 = dbg_addr; e.wd = dbg_wdata; e.chk_a3 = e.we;
      p_wr = e.we; p_wa = dbg_addr; p_wd = dbg_wdata; p_starve = 0;
    end else begin
      e.we = core_we && (core_wa != 0);
      e.a3 = core_wa; e.wd = core_wd; e.chk_a3 = e.we;
      p_wr = e.we; p_wa = core_wa; p_wd = core_wd;
      p_starve = (dbg_valid && dbg_wr) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
    end
    last_ready = e.ready;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic cwe, input logic [AW-1:0] cwa,
                       input logic [DW-1:0] cwd, input logic [AW-1:0] ca1,
                       input logic dv, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd);
    @(posedge clk);
    commit();
    #1;
    stub_init = 1'b0;
    rst_n = r; core_we = cwe; core_wa = cwa; core_wd = cwd; core_a1 = ca1;
    dbg_valid = dv; dbg_wr = dw; dbg_addr = da; dbg_wdata = dd;
    predict();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
  endfunction

  task automatic rand_cycle(input logic r, input logic hold);
    logic          dv, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    if (hold && $urandom_range(0, 9) != 0) begin
      dv = 1'b1; dw = 1'b1; da = dbg_addr; dd = dbg_wdata;
    end else begin
      dv = ($urandom_range(0, 1) == 1);
      dw = ($urandom_range(0, 4) < 3);
      da = rand_addr();
      dd = $urandom;
    end
    drive(r, ($urandom_range(0, 9) < 7), rand_addr(), $urandom, rand_addr(), dv, dw, da, dd);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected response per presented cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_stall", DW'(core_stall), DW'(e.stall));
        chk("dbg_ready", DW'(dbg_ready), DW'(e.ready));
        chk("rf_WE3", DW'(rf_WE3), DW'(e.we));
        if (e.chk_a3) begin
          chk("rf_A3", DW'(rf_A3), DW'(e.a3));
          chk("rf_WD3", rf_WD3, e.wd);
        end
        if (e.chk_a1) chk("rf_A1", DW'(rf_A1), DW'(e.a1));
        chk("dbg_rvalid", DW'(dbg_rvalid), DW'(e.rvalid));
        chk("dbg_rdata", dbg_rdata, e.rdata);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREG; i++) m_mem[i] = seed(i);
    stub_init = 1'b1;
    rst_n = 1'b0; core_we = 1'b0; core_wa = '0; core_wd = '0; core_a1 = '0;
    dbg_valid = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset, then drop reset again ten cycles into the clear
    drive(1'b0, 1'b1, 5'd3, 32'h1, 5'd4, 1'b1, 1'b1, 5'd6, 32'h2);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) rand_cycle(1'b1, 1'b0);
    drive(1'b0, 1'b1, 5'd8, 32'h5, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0);
    for (int i = 0; i < NREG + 2; i++) rand_cycle(1'b1, 1'b0);

    // Directed: pass-through, address 0, idle-core debug write, starvation, reads
    drive(1'b1, 1'b1, 5'd2, 32'h3, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b1, 5'd0, 32'h9, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, AW'(10 + i), DW'(i), 5'd3, 1'b1, 1'b1, 5'd7, 32'h0000_0777);
    drive(1'b1, 1'b1, 5'd3, 32'h33, 5'd1, 1'b1, 1'b0, 5'd5, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 1'b1, 1'b0, 5'd7, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b1, 5'd2, 32'h4, 5'd2, 1'b1, 1'b1, 5'd0, 32'h1234);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0);

    // Randomized traffic; a refused debug write is usually re-presented
    for (int n = 0; n < 700; n++) begin
      rand_cycle(($urandom_range(0, 249) != 0), dbg_valid && dbg_wr && !last_ready);
    end

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
